// File: rtl/per_transmissor_pkg.sv
// Shared handshake definitions for the peripheral -> CPU transmitter.
// The state encodings are the ones the CPU and PERIFERICO sides use as well.
package per_transmissor_pkg;

    localparam int unsigned DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } hs_state_e;

endpackage

// File: rtl/per_transmissor_sincronizador.sv
// Reset-to-zero flop chain that brings an asynchronous level into the local clock domain.
module sincronizador #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the sampled level through the chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/per_transmissor.sv
// Peripheral-side transmitter: buffers local words in a FIFO and offers each one
// to the CPU over a 4-phase send/ack handshake, with the ack synchronized locally.
module per_transmissor
    import per_transmissor_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic              per_clock,
    input  logic              per_reset,
    input  logic [DATA_W-1:0] in_dados,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              per_send,
    output logic [DATA_W-1:0] out_per_dados,
    input  logic              cpu_ack,
    output logic              busy,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [7:0]        sent_count
);

    logic              ack_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    hs_state_e         state_q, state_d;
    logic              send_q, send_d;
    logic [DATA_W-1:0] dados_q, dados_d;
    logic [7:0]        sent_q, sent_d;

    sincronizador #(
        .STAGES (SYNC_STAGES)
    ) u_sync_ack (
        .clk_i  (per_clock),
        .rst_ni (per_reset),
        .d_i    (cpu_ack),
        .q_o    (ack_s)
    );

    // Readiness looks only at registered occupancy, never at this cycle's pop
    assign full_s   = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_s  = (count_q == '0);
    assign in_ready = !full_s;
    assign push_s   = in_valid & in_ready;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // FIFO storage and pointer registers
    always_ff @(posedge per_clock or negedge per_reset) begin
        if (!per_reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= in_dados;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Handshake FSM; a stale ack in IDLE holds off the next offer
    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        dados_d = dados_q;
        sent_d  = sent_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s && !ack_s) begin
                    pop_s   = 1'b1;
                    dados_d = mem_q[rd_ptr_q];
                    send_d  = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    send_d  = 1'b0;
                end
            end
            ST_SEND: begin
                if (ack_s) begin
                    send_d  = 1'b0;
                    state_d = ST_WAIT_LOW;
                end else begin
                    send_d  = 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                if (!ack_s) begin
                    sent_d  = sent_q + 8'd1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LOW;
                end
            end
            default: begin
                send_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge per_clock or negedge per_reset) begin
        if (!per_reset) begin
            state_q <= ST_IDLE;
            send_q  <= 1'b0;
            dados_q <= '0;
            sent_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            dados_q <= dados_d;
            sent_q  <= sent_d;
        end
    end

    assign per_send      = send_q;
    assign out_per_dados = dados_q;
    assign sent_count    = sent_q;
    assign fifo_count    = count_q;
    assign busy          = (state_q != ST_IDLE) | (count_q != '0);

endmodule

// File: tb/tb_per_transmissor.sv
// Self-checking bench: CPU-side responder on its own clock plus a word-order model.
module tb_per_transmissor;

    logic       per_clock = 1'b0;
    logic       cpu_clk   = 1'b0;
    logic       per_reset = 1'b0;
    logic [3:0] in_dados  = 4'h0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic       per_send;
    logic [3:0] out_per_dados;
    logic       cpu_ack;
    logic       busy;
    logic [2:0] fifo_count;
    logic [7:0] sent_count;

    int checks   = 0;
    int failures = 0;

    logic [3:0] rx_q[$];
    logic [3:0] exp_q[$];

    bit   resp_en   = 1'b1;
    bit   ack_force = 1'b0;
    logic ack_r     = 1'b0;
    int   hi_cnt    = 0;
    int   lo_cnt    = 0;

    per_transmissor dut (
        .per_clock     (per_clock),
        .per_reset     (per_reset),
        .in_dados      (in_dados),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .per_send      (per_send),
        .out_per_dados (out_per_dados),
        .cpu_ack       (cpu_ack),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .sent_count    (sent_count)
    );

    always #5 per_clock = ~per_clock;
    always #7 cpu_clk   = ~cpu_clk;

    assign cpu_ack = ack_force | ack_r;

    // CPU responder: ack 3 cycles after seeing send, drop 3 cycles after send falls
    always @(posedge cpu_clk) begin
        if (!resp_en) begin
            ack_r  <= 1'b0;
            hi_cnt <= 0;
            lo_cnt <= 0;
        end else if (!ack_r) begin
            lo_cnt <= 0;
            if (per_send) begin
                if (hi_cnt == 2) begin
                    ack_r  <= 1'b1;
                    hi_cnt <= 0;
                    rx_q.push_back(out_per_dados);
                end else begin
                    hi_cnt <= hi_cnt + 1;
                end
            end else begin
                hi_cnt <= 0;
            end
        end else begin
            hi_cnt <= 0;
            if (!per_send) begin
                if (lo_cnt == 2) begin
                    ack_r  <= 1'b0;
                    lo_cnt <= 0;
                end else begin
                    lo_cnt <= lo_cnt + 1;
                end
            end else begin
                lo_cnt <= 0;
            end
        end
    end

    // Reference model: every accepted word must come out once, in order
    always @(posedge per_clock) begin
        if (per_reset && in_valid && in_ready) begin
            exp_q.push_back(in_dados);
        end
    end

    logic       prev_send = 1'b0;
    logic [3:0] prev_data = 4'h0;

    // Offered word must not change while per_send stays high
    always @(negedge per_clock) begin
        if (prev_send && per_send) begin
            checks++;
            if (out_per_dados !== prev_data) begin
                failures++;
                $display("FAIL data_stable actual=%0h required=%0h", out_per_dados, prev_data);
            end
        end
        prev_send = per_send;
        prev_data = out_per_dados;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge per_clock);
        while ((busy || per_send || cpu_ack) && n < 3000) begin
            @(negedge per_clock);
            n++;
        end
        if (busy || per_send || cpu_ack) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=idle", nm);
        end
    endtask

    task automatic push_word(input logic [3:0] d);
        int n = 0;
        @(negedge per_clock);
        while (!in_ready && n < 3000) begin
            @(negedge per_clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=0 required=1");
        end
        in_valid = 1'b1;
        in_dados = d;
        @(negedge per_clock);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge per_clock);
        per_reset = 1'b0;
        repeat (3) @(negedge per_clock);
        per_reset = 1'b1;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_list(input string nm, input logic [3:0] want[$]);
        check({nm, "_count"}, rx_q.size(), want.size());
        for (int i = 0; i < want.size() && i < rx_q.size(); i++) begin
            check({nm, "_word"}, rx_q[i], want[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [3:0] din;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t       vt[6];
    logic [3:0] want[$];
    logic [3:0] d;
    logic [7:0] base;

    initial begin
        vt[0] = '{4'hA, 8'd1};
        vt[1] = '{4'h0, 8'd2};
        vt[2] = '{4'hF, 8'd3};
        vt[3] = '{4'h5, 8'd4};
        vt[4] = '{4'hC, 8'd5};
        vt[5] = '{4'h3, 8'd6};

        #23;
        check("rst_send", per_send, 1'b0);
        check("rst_data", out_per_dados, 4'h0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo", fifo_count, 3'd0);
        check("rst_sent", sent_count, 8'd0);
        @(negedge per_clock);
        per_reset = 1'b1;

        // Single words into an idle block: latency, held data, completion count
        for (int i = 0; i < 6; i++) begin
            @(negedge per_clock);
            in_valid = 1'b1;
            in_dados = vt[i].din;
            @(posedge per_clock);
            #1;
            in_valid = 1'b0;
            check("lat_fifo_n", fifo_count, 3'd1);
            check("lat_send_n", per_send, 1'b0);
            @(posedge per_clock);
            #1;
            check("lat_send_n1", per_send, 1'b1);
            check("lat_data", out_per_dados, vt[i].din);
            wait_idle("single");
            check("single_sent", sent_count, vt[i].exp_cnt);
            check("single_busy", busy, 1'b0);
            want = '{vt[i].din};
            compare_list("single", want);
        end

        // Stale ack out of reset holds off the offer
        ack_force = 1'b1;
        do_reset();
        push_word(4'h7);
        for (int i = 0; i < 20; i++) begin
            @(negedge per_clock);
            if (per_send !== 1'b0) check("stale_send", per_send, 1'b0);
        end
        check("stale_fifo", fifo_count, 3'd1);
        check("stale_send_end", per_send, 1'b0);
        ack_force = 1'b0;
        wait_idle("stale");
        want = '{4'h7};
        compare_list("stale", want);
        check("stale_sent", sent_count, 8'd1);

        // Fill to full while ack is held, then drain in order
        ack_force = 1'b1;
        repeat (6) @(negedge per_clock);
        for (int i = 1; i <= 4; i++) push_word(4'(i));
        check("full_fifo", fifo_count, 3'd4);
        check("full_ready", in_ready, 1'b0);
        ack_force = 1'b0;
        wait_idle("burst");
        want = '{4'h1, 4'h2, 4'h3, 4'h4};
        compare_list("burst", want);
        check("burst_sent", sent_count, 8'd5);

        // Push held while full; the pop cycle must not accept it
        ack_force = 1'b1;
        repeat (6) @(negedge per_clock);
        for (int i = 11; i <= 14; i++) push_word(4'(i));
        @(negedge per_clock);
        in_valid  = 1'b1;
        in_dados  = 4'hF;
        ack_force = 1'b0;
        begin
            int n = 0;
            while (fifo_count == 3'd4 && n < 200) begin
                @(negedge per_clock);
                n++;
            end
        end
        check("fullpop_fifo", fifo_count, 3'd3);
        check("fullpop_ready", in_ready, 1'b1);
        @(posedge per_clock);
        #1;
        check("fullpop_refill", fifo_count, 3'd4);
        @(negedge per_clock);
        in_valid = 1'b0;
        wait_idle("fullpop");
        want = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        compare_list("fullpop", want);
        check("fullpop_sent", sent_count, 8'd10);

        // Reset in SEND with two words queued
        resp_en = 1'b0;
        push_word(4'h1);
        push_word(4'h2);
        push_word(4'h3);
        repeat (3) @(negedge per_clock);
        check("mid_pre_send", per_send, 1'b1);
        check("mid_pre_fifo", fifo_count, 3'd2);
        #2;
        per_reset = 1'b0;
        #1;
        check("mid_rst_send", per_send, 1'b0);
        check("mid_rst_fifo", fifo_count, 3'd0);
        check("mid_rst_sent", sent_count, 8'd0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge per_clock);
        per_reset = 1'b1;
        rx_q.delete();
        exp_q.delete();
        resp_en = 1'b1;
        push_word(4'h5);
        wait_idle("mid");
        want = '{4'h5};
        compare_list("mid", want);
        check("mid_sent", sent_count, 8'd1);

        // 256 random single-word transfers: counter wraps, nothing else disturbed
        do_reset();
        want.delete();
        for (int i = 0; i < 256; i++) begin
            d = 4'($urandom);
            want.push_back(d);
            repeat ($urandom_range(0, 3)) @(negedge per_clock);
            push_word(d);
            wait_idle("wrap");
            if (i == 254) check("wrap_255", sent_count, 8'd255);
        end
        check("wrap_0", sent_count, 8'd0);
        check("wrap_busy", busy, 1'b0);
        check("wrap_fifo", fifo_count, 3'd0);
        check("wrap_ready", in_ready, 1'b1);
        compare_list("wrap", want);

        // Random valid pattern against the order model
        base = sent_count;
        for (int i = 0; i < 120; i++) begin
            @(negedge per_clock);
            in_valid = 1'($urandom_range(0, 1));
            in_dados = 4'($urandom);
        end
        @(negedge per_clock);
        in_valid = 1'b0;
        wait_idle("rand");
        check("rand_sent", sent_count, 8'(base + 8'(exp_q.size())));
        want = exp_q;
        compare_list("rand", want);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
